// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered on grant, the result is captured one cycle later and returned with the requester id.
module alu_arbiter #(
   parameter int WIDTH = 8,
   parameter int OPW   = 3,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry_out,
   input  logic             alu_c_flag,
   input  logic             alu_zero_flag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   output logic             rsp_cflag,
   output logic             rsp_zero,
   output logic [CNTW-1:0]  op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [OPW-1:0]   op;
   } alu_req_t;

   state_t   state;
   logic     prio;
   logic     cur_id;
   logic     win_id;
   alu_req_t win_req;

   // prio names the requester that wins a tie; it flips to the other id after each response
   always_comb begin
      win_id = req1_valid;
      if (req0_valid && req1_valid) win_id = prio;
      win_req = win_id ? alu_req_t'{req1_a, req1_b, req1_op}
                       : alu_req_t'{req0_a, req0_b, req0_op};
   end

   assign req0_ready = (state == IDLE) && req0_valid && !win_id;
   assign req1_ready = (state == IDLE) && req1_valid &&  win_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         prio      <= 1'b0;
         cur_id    <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_cflag <= 1'b0;
         rsp_zero  <= 1'b0;
         op_count  <= '0;
      end else begin
         case (state)
            IDLE: if (req0_valid || req1_valid) begin
               cur_id <= win_id;
               alu_a  <= win_req.a;
               alu_b  <= win_req.b;
               alu_op <= win_req.op;
               state  <= EXEC;
            end
            EXEC: begin
               rsp_valid <= 1'b1;
               rsp_id    <= cur_id;
               rsp_data  <= alu_out;
               rsp_carry <= alu_carry_out;
               rsp_cflag <= alu_c_flag;
               rsp_zero  <= alu_zero_flag;
               state     <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               prio      <= ~rsp_id;
               if (op_count != '1) op_count <= op_count + CNTW'(1);
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU between two requesters.
- Each requester presents operands a, b and a 3-bit op_code with a valid/ready handshake. The block grants round-robin, registers operands, drives the ALU and captures out/carry_out/c_flag/zero_flag.
- It returns the result on a single response channel tagged with the requester id.
- It sits between the ALU instance and two issuing units, such as a sequencer and a debug/test port.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU data width.
- OPW, 3, op_code width; must match the ALU op_code width.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand a
- req0_b  input  WIDTH  requester 0 operand b
- req0_op  input  OPW  requester 0 op_code
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths as requester 0, for requester 1
- alu_a  output  WIDTH  to ALU a
- alu_b  output  WIDTH  to ALU b
- alu_op  output  OPW  to ALU op_code
- alu_out  input  WIDTH  from ALU out
- alu_carry_out  input  1  from ALU carry_out
- alu_c_flag  input  1  from ALU c_flag
- alu_zero_flag  input  1  from ALU zero_flag
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the response (0/1)
- rsp_data  output  WIDTH  captured ALU out
- rsp_carry  output  1  captured carry_out
- rsp_cflag  output  1  captured c_flag
- rsp_zero  output  1  captured zero_flag
- op_count  output  CNTW  completed responses, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, prio = 0.
  - alu_a, alu_b, alu_op = 0.
  - rsp_valid = 0; rsp_id, rsp_data, rsp_carry, rsp_cflag, rsp_zero = 0.
  - op_count = 0.
  - req0_ready, req1_ready = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = the only valid requester. If both are valid, the winner is the requester equal to prio.
  - reqN_ready is combinational: high only in IDLE, for the winner only, and only while its valid is high.
  - On handshake edge E0, latch the winner's a/b/op into alu_a/alu_b/alu_op, latch the winner's id, and go to EXEC.
  - With no valid, stay in IDLE.
- EXEC:
  - Lasts one cycle while the ALU settles on the registered operands.
  - At edge E1, capture alu_out/carry/c_flag/zero into the rsp_* registers, set rsp_valid = 1, go to RESP.
- RESP:
  - rsp_* hold stable while rsp_valid = 1 and rsp_ready = 0 (unbounded backpressure).
  - At an edge with rsp_ready = 1 (E2 or later): rsp_valid = 0, prio = the other id, op_count += 1 (holds at all-ones), go to IDLE.
- Latency and throughput:
  - rsp_valid is high in the cycle after E1, i.e. 2 edges after acceptance.
  - Earliest next acceptance is the edge after the response handshake, giving a minimum of 3 cycles per operation.
- No request is accepted while in EXEC or RESP. Both readys are 0 there.
- Requesters must hold valid/a/b/op stable until ready. A valid drop before ready is legal; that request is simply not taken.
- Fairness: the requester just served has the lower priority at the next contention, so with continuous contention grants alternate 0,1,0,1 from reset.
- alu_a/alu_b/alu_op keep their last values after completion; they change only at acceptance.
- rsp_ready while rsp_valid = 0 is ignored.
- rst_n low mid-operation, in any state: all registers return to reset values immediately (asynchronous). Any pending response is discarded and not counted.
- op_count saturates at 2^CNTW-1. It never wraps.

Test Plan:
- Bench ALU stub for all scenarios: out = (a+b)[7:0], carry_out = c_flag = bit 8 of a+b, zero_flag = (out == 0), for every op.
- Single request: req0 a=0x07 b=0x05 op=000 with rsp_ready=1 -> req0_ready for 1 cycle; alu_op=000; rsp_valid 2 edges after acceptance with rsp_id=0, rsp_data=0x0C, carry=0, zero=0; op_count=1.
- Contention: req0 and req1 held valid continuously, rsp_ready=1 -> grant order from reset is 0,1,0,1; each op takes 3 cycles; 4 responses arrive with alternating rsp_id.
- Backpressure: req1 a=0xFF b=0x01, rsp_ready=0 for 5 cycles -> rsp_valid held with rsp_data=0x00, carry=1, cflag=1, zero=1 stable throughout; no readys asserted; completes on the rsp_ready edge.
- Reset mid-op: assert rst_n=0 during EXEC -> all outputs 0 immediately, op_count unchanged from its pre-reset value of 0, no response issued; first request after release is granted to req0.
- Saturation: with CNTW=2, complete 5 ops -> op_count reads 1,2,3,3,3.
